// File: rtl/uc_pkg.sv
// Shared encodings for the stack-machine control unit and its ALU: states,
// opcodes and instruction field positions.
package uc_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    WAIT_MEM = 4'd2,
    DECODE   = 4'd3,
    IMM      = 4'd4,
    PUSH     = 4'd5,
    LOAD_B   = 4'd6,
    POP_B    = 4'd7,
    LOAD_A   = 4'd8,
    POP_A    = 4'd9,
    EXEC     = 4'd10,
    WRITE    = 4'd11,
    POP      = 4'd12,
    HALT     = 4'd13,
    ERROR    = 4'd14
  } state_t;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_NAND = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_PUSH = 5'b01000;
  localparam logic [OPC_W-1:0] OP_POP  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11110;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11111;

  // The eight ALU operations occupy the codes 00000..00111.
  function automatic logic is_alu(input logic [OPC_W-1:0] op);
    return (op[4:3] == 2'b00);
  endfunction

endpackage

// File: rtl/unidade_controle.sv
// Control unit for a 16-bit stack machine: fetches from a synchronous ROM,
// sequences the stack/temp-register datapath and tracks stack depth.
module unidade_controle
  import uc_pkg::*;
#(
  parameter int STACK_DEPTH = 16,
  parameter int PC_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [PC_W-1:0]    pc_addr,
  input  logic [15:0]        instr_in,
  output logic [15:0]        din_UC,
  output logic [4:0]         opcode,
  output logic               wren,
  output logic               controle_pilha,
  output logic               load_temp1,
  output logic               load_temp2,
  output logic               clk_pilha,
  output logic               clk_temp1,
  output logic               clk_temp2,
  output logic               busy,
  output logic               halted,
  output logic               error
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);

  state_t              state, state_nx;
  logic                imm_phase, imm_phase_nx;
  logic [PC_W-1:0]     pc, pc_nx;
  logic [DEPTH_W-1:0]  depth, depth_nx;
  logic [OPC_W-1:0]    instr_op;

  logic [15:0]         din_nx;
  logic [4:0]          opcode_nx;
  logic wren_nx, cp_nx, lt1_nx, lt2_nx, pil_nx, t1_nx, t2_nx;
  logic busy_nx, halted_nx, error_nx;

  assign instr_op = instr_in[OPC_MSB:OPC_LSB];
  assign pc_addr  = pc;

  always_comb begin
    state_nx     = state;
    imm_phase_nx = 1'b0;
    pc_nx        = pc;
    depth_nx     = depth;
    unique case (state)
      IDLE:     if (run) state_nx = FETCH;
      FETCH:    state_nx = WAIT_MEM;
      WAIT_MEM: state_nx = DECODE;
      DECODE: begin
        pc_nx = pc + PC_W'(1);
        if (is_alu(instr_op)) begin
          state_nx = (depth < DEPTH_TWO) ? ERROR : LOAD_B;
        end else begin
          unique case (instr_op)
            OP_PUSH: state_nx = (depth == DEPTH_FULL) ? ERROR : IMM;
            OP_POP:  state_nx = (depth == '0) ? ERROR : POP;
            OP_NOP:  state_nx = FETCH;
            OP_HALT: state_nx = HALT;
            default: state_nx = ERROR;
          endcase
        end
      end
      // First IMM cycle presents the immediate address, second sees the ROM data.
      IMM: begin
        if (!imm_phase) begin
          imm_phase_nx = 1'b1;
        end else begin
          state_nx = PUSH;
          pc_nx    = pc + PC_W'(1);
        end
      end
      PUSH: begin
        depth_nx = depth + DEPTH_ONE;
        state_nx = FETCH;
      end
      LOAD_B: state_nx = POP_B;
      POP_B: begin
        depth_nx = depth - DEPTH_ONE;
        state_nx = LOAD_A;
      end
      LOAD_A: state_nx = POP_A;
      POP_A: begin
        depth_nx = depth - DEPTH_ONE;
        state_nx = EXEC;
      end
      EXEC:  state_nx = WRITE;
      WRITE: begin
        depth_nx = depth + DEPTH_ONE;
        state_nx = FETCH;
      end
      POP: begin
        depth_nx = depth - DEPTH_ONE;
        state_nx = FETCH;
      end
      HALT:    state_nx = HALT;
      ERROR:   state_nx = ERROR;
      default: state_nx = ERROR;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each strobe
  // is high for exactly the cycle spent in its state.
  always_comb begin
    din_nx    = din_UC;
    opcode_nx = opcode;
    if (state == IMM && state_nx == PUSH)      din_nx    = instr_in;
    if (state == DECODE && state_nx == LOAD_B) opcode_nx = instr_op;
    wren_nx   = (state_nx == PUSH) || (state_nx == WRITE);
    cp_nx     = (state_nx == WRITE);
    lt2_nx    = (state_nx == LOAD_B);
    t2_nx     = (state_nx == LOAD_B);
    lt1_nx    = (state_nx == LOAD_A);
    t1_nx     = (state_nx == LOAD_A);
    pil_nx    = (state_nx == PUSH) || (state_nx == POP_B) || (state_nx == POP_A) ||
                (state_nx == WRITE) || (state_nx == POP);
    busy_nx   = !((state_nx == IDLE) || (state_nx == HALT) || (state_nx == ERROR));
    halted_nx = (state_nx == HALT);
    error_nx  = (state_nx == ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      imm_phase      <= 1'b0;
      pc             <= '0;
      depth          <= '0;
      din_UC         <= '0;
      opcode         <= '0;
      wren           <= 1'b0;
      controle_pilha <= 1'b0;
      load_temp1     <= 1'b0;
      load_temp2     <= 1'b0;
      clk_pilha      <= 1'b0;
      clk_temp1      <= 1'b0;
      clk_temp2      <= 1'b0;
      busy           <= 1'b0;
      halted         <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_nx;
      imm_phase      <= imm_phase_nx;
      pc             <= pc_nx;
      depth          <= depth_nx;
      din_UC         <= din_nx;
      opcode         <= opcode_nx;
      wren           <= wren_nx;
      controle_pilha <= cp_nx;
      load_temp1     <= lt1_nx;
      load_temp2     <= lt2_nx;
      clk_pilha      <= pil_nx;
      clk_temp1      <= t1_nx;
      clk_temp2      <= t2_nx;
      busy           <= busy_nx;
      halted         <= halted_nx;
      error          <= error_nx;
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: instruction-level reference model, a small
// stack datapath driven by the DUT strobes, directed and random programs.
module tb_unidade_controle;
  import uc_pkg::*;

  localparam int DEPTH = 16;

  localparam logic [9:0] F_WREN = 10'h200;
  localparam logic [9:0] F_CP   = 10'h100;
  localparam logic [9:0] F_LT1  = 10'h080;
  localparam logic [9:0] F_LT2  = 10'h040;
  localparam logic [9:0] F_PIL  = 10'h020;
  localparam logic [9:0] F_T1   = 10'h010;
  localparam logic [9:0] F_T2   = 10'h008;
  localparam logic [9:0] F_BUSY = 10'h004;
  localparam logic [9:0] F_HALT = 10'h002;
  localparam logic [9:0] F_ERR  = 10'h001;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [7:0]  pc_addr;
  logic [15:0] instr_in;
  logic [15:0] din_UC;
  logic [4:0]  opcode;
  logic wren, controle_pilha, load_temp1, load_temp2;
  logic clk_pilha, clk_temp1, clk_temp2, busy, halted, error;

  always #5 clk = ~clk;

  unidade_controle #(.STACK_DEPTH(DEPTH), .PC_W(8)) dut (
    .clk(clk), .reset(reset), .run(run), .pc_addr(pc_addr), .instr_in(instr_in),
    .din_UC(din_UC), .opcode(opcode), .wren(wren), .controle_pilha(controle_pilha),
    .load_temp1(load_temp1), .load_temp2(load_temp2), .clk_pilha(clk_pilha),
    .clk_temp1(clk_temp1), .clk_temp2(clk_temp2), .busy(busy), .halted(halted),
    .error(error)
  );

  // Synchronous program ROM, one cycle read latency.
  logic [15:0] rom [0:255];
  always @(posedge clk) instr_in <= rom[pc_addr];

  // Stack datapath reacting to the strobes.
  logic [15:0] dp_mem [0:63];
  logic [15:0] t1r, t2r;
  int dp_sp, pilha_cnt, strobe_cnt;

  function automatic logic [15:0] alu(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_DIV:  return (b == 0) ? 16'd0 : a / b;
      OP_AND:  return a & b;
      OP_NAND: return ~(a & b);
      OP_OR:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      dp_sp      <= 0;
      pilha_cnt  <= 0;
      strobe_cnt <= 0;
    end else begin
      if (clk_pilha) pilha_cnt <= pilha_cnt + 1;
      if (clk_pilha || clk_temp1 || clk_temp2) strobe_cnt <= strobe_cnt + 1;
      if (clk_temp2 && dp_sp > 0) t2r <= dp_mem[6'(dp_sp - 1)];
      if (clk_temp1 && dp_sp > 0) t1r <= dp_mem[6'(dp_sp - 1)];
      if (clk_pilha) begin
        if (!wren) begin
          if (dp_sp > 0) dp_sp <= dp_sp - 1;
        end else begin
          dp_mem[6'(dp_sp)] <= controle_pilha ? alu(opcode, t1r, t2r) : din_UC;
          dp_sp <= dp_sp + 1;
        end
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_vec(input string name, input logic [38:0] act, input logic [38:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [38:0] dut_vec();
    return {pc_addr, din_UC, opcode, wren, controle_pilha, load_temp1, load_temp2,
            clk_pilha, clk_temp1, clk_temp2, busy, halted, error};
  endfunction

  function automatic logic [38:0] mk(input int p, input logic [15:0] din,
                                     input logic [4:0] op, input logic [9:0] f);
    return {8'(p), din, op, f};
  endfunction

  // Reference model: walk the program instruction by instruction and list
  // the outputs expected in each cycle, starting with the IDLE cycle.
  logic [38:0] exp_q[$];
  int m_depth;

  task automatic build(input int max_cycles);
    int p = 0;
    int d = 0;
    logic [15:0] din = '0;
    logic [4:0]  op = '0;
    logic [4:0]  code;
    logic [15:0] word;
    logic [38:0] term = '0;
    bit done = 0;
    exp_q.delete();
    exp_q.push_back(mk(0, 16'd0, 5'd0, 10'd0));
    while (!done && exp_q.size() < max_cycles) begin
      word = rom[p];
      code = word[15:11];
      repeat (3) exp_q.push_back(mk(p, din, op, F_BUSY));
      p = (p + 1) % 256;
      if (code <= 5'd7) begin
        if (d < 2) begin
          term = mk(p, din, op, F_ERR); done = 1;
        end else begin
          op = code;
          exp_q.push_back(mk(p, din, op, F_LT2 | F_T2 | F_BUSY));
          exp_q.push_back(mk(p, din, op, F_PIL | F_BUSY));
          exp_q.push_back(mk(p, din, op, F_LT1 | F_T1 | F_BUSY));
          exp_q.push_back(mk(p, din, op, F_PIL | F_BUSY));
          exp_q.push_back(mk(p, din, op, F_BUSY));
          exp_q.push_back(mk(p, din, op, F_WREN | F_CP | F_PIL | F_BUSY));
          d = d - 1;
        end
      end else if (code == OP_PUSH) begin
        if (d == DEPTH) begin
          term = mk(p, din, op, F_ERR); done = 1;
        end else begin
          repeat (2) exp_q.push_back(mk(p, din, op, F_BUSY));
          din = rom[p];
          p = (p + 1) % 256;
          exp_q.push_back(mk(p, din, op, F_WREN | F_PIL | F_BUSY));
          d = d + 1;
        end
      end else if (code == OP_POP) begin
        if (d == 0) begin
          term = mk(p, din, op, F_ERR); done = 1;
        end else begin
          exp_q.push_back(mk(p, din, op, F_PIL | F_BUSY));
          d = d - 1;
        end
      end else if (code == OP_HALT) begin
        term = mk(p, din, op, F_HALT); done = 1;
      end else if (code != OP_NOP) begin
        term = mk(p, din, op, F_ERR); done = 1;
      end
    end
    if (done) while (exp_q.size() < max_cycles) exp_q.push_back(term);
    m_depth = d;
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int a = 0; a < 256; a++) rom[a] = w;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Compare the DUT against the model on every cycle of the run.
  task automatic run_program(input int max_cycles, input bit do_rst, input bit rand_run);
    if (do_rst) do_reset();
    build(max_cycles);
    run = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      check_vec($sformatf("cycle%0d", i), dut_vec(), exp_q[i]);
      @(negedge clk);
      if (rand_run) run = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    bit found;
    int r;
    logic [15:0] w;
    reset = 1'b0;
    run   = 1'b0;
    fill_rom({OP_HALT, 11'd0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_vec("reset_state", dut_vec(), 39'd0);

    // PUSH 4, PUSH 2, ADD, HALT
    fill_rom({OP_HALT, 11'd0});
    rom[0] = {OP_PUSH, 11'd0}; rom[1] = 16'd4;
    rom[2] = {OP_PUSH, 11'd0}; rom[3] = 16'd2;
    rom[4] = {OP_ADD, 11'd0};  rom[5] = {OP_HALT, 11'd0};
    run_program(40, 1, 0);
    check_vec("model_add_write", exp_q[21], mk(5, 16'd2, OP_ADD, F_WREN | F_CP | F_PIL | F_BUSY));
    check_vec("model_add_halt", exp_q[25], mk(6, 16'd2, OP_ADD, F_HALT));
    check_int("add_model_depth", m_depth, 1);
    check_int("add_pilha_strobes", pilha_cnt, 5);
    check_int("add_stack_depth", dp_sp, 1);
    check_int("add_tos", int'(dp_mem[6'(dp_sp - 1)]), 6);
    check_int("add_halted", int'(halted), 1);

    // ALU op on an empty stack
    fill_rom({OP_HALT, 11'd0});
    rom[0] = {OP_ADD, 11'd0};
    run_program(12, 1, 0);
    check_vec("model_underflow", exp_q[4], mk(1, 16'd0, 5'd0, F_ERR));
    check_int("underflow_pilha", pilha_cnt, 0);
    check_int("underflow_error", int'(error), 1);

    // 17 pushes overflow the 16-entry stack
    fill_rom({OP_HALT, 11'd0});
    for (int k = 0; k < 17; k++) begin
      rom[2 * k] = {OP_PUSH, 11'd0};
      rom[2 * k + 1] = 16'(k + 1);
    end
    run_program(6 * 17 + 10, 1, 0);
    check_int("overflow_model_depth", m_depth, 16);
    check_int("overflow_pilha", pilha_cnt, 16);
    check_int("overflow_stack", dp_sp, 16);
    check_int("overflow_error", int'(error), 1);

    // illegal opcode
    fill_rom({OP_HALT, 11'd0});
    rom[0] = {5'b10101, 11'd0};
    run_program(10, 1, 0);
    check_vec("model_illegal", exp_q[4], mk(1, 16'd0, 5'd0, F_ERR));
    check_int("illegal_strobes", strobe_cnt, 0);
    check_int("illegal_error", int'(error), 1);

    // reset during POP_B of SUB, then restart from address 0
    fill_rom({OP_HALT, 11'd0});
    rom[0] = {OP_PUSH, 11'd0}; rom[1] = 16'd9;
    rom[2] = {OP_PUSH, 11'd0}; rom[3] = 16'd3;
    rom[4] = {OP_SUB, 11'd0};  rom[5] = {OP_HALT, 11'd0};
    do_reset();
    run = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (clk_pilha && !wren && opcode == OP_SUB) found = 1;
    end
    check_int("popb_reached", int'(found), 1);
    if (found) begin
      reset = 1'b0;
      #1;
      check_vec("mid_reset_outputs", dut_vec(), 39'd0);
      @(negedge clk);
      reset = 1'b1;
      run_program(40, 0, 0);
      check_int("sub_tos", int'(dp_mem[6'(dp_sp - 1)]), 6);
    end

    // NOPs everywhere: pc wraps 255 -> 0 without error
    fill_rom({OP_NOP, 11'd5});
    run_program(800, 1, 0);
    check_vec("model_pc255", exp_q[1 + 255 * 3], mk(255, 16'd0, 5'd0, F_BUSY));
    check_vec("model_pc_wrap", exp_q[1 + 256 * 3], mk(0, 16'd0, 5'd0, F_BUSY));

    // random programs, run toggled freely after start
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < 256; a++) begin
        r = $urandom_range(0, 99);
        w = 16'($urandom);
        if (r < 35)      w[15:11] = OP_PUSH;
        else if (r < 65) w[15:11] = 5'($urandom_range(0, 7));
        else if (r < 75) w[15:11] = OP_POP;
        else if (r < 90) w[15:11] = OP_NOP;
        else if (r < 93) w[15:11] = OP_HALT;
        else             w[15:11] = 5'($urandom_range(10, 29));
        rom[a] = w;
      end
      run_program(300, 1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
